// File: rtl/lzss_decoder_if.sv
// Token-in / word-out handshake bundle for the LZSS decoder.
// The master side supplies tokens and consumes words; the slave side is the decoder.
interface lzss_decoder_if #(
  parameter int WORD_SIZE = 8
);
  logic                 w_en;
  logic [WORD_SIZE:0]   data_i;
  logic                 i_ready;
  logic [WORD_SIZE-1:0] data_o;
  logic                 o_valid;
  logic                 rd_en;

  modport master (
    output w_en, data_i, rd_en,
    input  i_ready, data_o, o_valid
  );

  modport slave (
    input  w_en, data_i, rd_en,
    output i_ready, data_o, o_valid
  );
endinterface

// File: rtl/lzss_decoder.sv
// LZSS token decoder.
// Expands literals and offset/length references into a byte stream, one word per cycle.
module lzss_decoder #(
  parameter int WORD_SIZE   = 8,
  parameter int WINDOW_SIZE = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  lzss_decoder_if.slave  bus,
  output logic           busy,
  output logic           err
);
  localparam int OFFSET_BITS      = $clog2(WINDOW_SIZE);
  localparam int LENGTH_BITS      = WORD_SIZE - OFFSET_BITS;
  localparam int MAX_LENGTH_VALUE = 2**LENGTH_BITS - 1;
  localparam int REM_W            = $clog2(MAX_LENGTH_VALUE + 1);
  localparam int FILL_W           = OFFSET_BITS + 1;

  typedef enum logic {IDLE, COPY} state_t;

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   hist_q [WINDOW_SIZE];
  logic [OFFSET_BITS-1:0] off_q, off_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [FILL_W-1:0]      fill_q;
  logic                   slot_free, accept, emit, err_set;
  logic [WORD_SIZE-1:0]   emit_word;
  logic                   tok_ref;
  logic [OFFSET_BITS-1:0] tok_off;
  logic [REM_W-1:0]       tok_len;

  assign slot_free   = !bus.o_valid || bus.rd_en;
  assign bus.i_ready = (state_q == IDLE) && slot_free;
  assign accept      = bus.w_en && bus.i_ready;
  assign busy        = (state_q == COPY);
  assign tok_ref     = bus.data_i[WORD_SIZE];
  assign tok_off     = bus.data_i[WORD_SIZE-1:LENGTH_BITS];
  assign tok_len     = bus.data_i[LENGTH_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    rem_d     = rem_q;
    emit      = 1'b0;
    emit_word = hist_q[off_q];
    err_set   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!tok_ref) begin
            emit      = 1'b1;
            emit_word = bus.data_i[WORD_SIZE-1:0];
          end else begin
            // Reaching past what has been emitted still copies (zeros) but is flagged.
            if ({1'b0, tok_off} >= fill_q) err_set = 1'b1;
            if (tok_len == '0) begin
              err_set = 1'b1;
            end else begin
              emit      = 1'b1;
              emit_word = hist_q[tok_off];
              if (tok_len != REM_W'(1)) begin
                state_d = COPY;
                off_d   = tok_off;
                rem_d   = tok_len - 1'b1;
              end
            end
          end
        end
      end
      COPY: begin
        // The history shifts on every emit, so a fixed offset replays overlapping runs.
        if (slot_free) begin
          emit  = 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q       <= '0;
      rem_q       <= '0;
      fill_q      <= '0;
      err         <= 1'b0;
      bus.data_o  <= '0;
      bus.o_valid <= 1'b0;
      for (int i = 0; i < WINDOW_SIZE; i++) hist_q[i] <= '0;
    end else begin
      off_q <= off_d;
      rem_q <= rem_d;
      if (err_set) err <= 1'b1;
      if (emit) begin
        bus.data_o  <= emit_word;
        bus.o_valid <= 1'b1;
        for (int i = WINDOW_SIZE-1; i > 0; i--) hist_q[i] <= hist_q[i-1];
        hist_q[0] <= emit_word;
        if (fill_q != FILL_W'(WINDOW_SIZE)) fill_q <= fill_q + 1'b1;
      end else if (bus.rd_en) begin
        bus.o_valid <= 1'b0;
      end
    end
  end
endmodule
